// File: rtl/rs_alu_param_if.sv
// Bundle between dispatch/writeback/ALU and the ALU reservation station.
// master: the side that dispatches ops, broadcasts wakeups and consumes issued ops.
// slave:  the reservation station itself.
`timescale 1ns/1ps
interface rs_alu_param_if #(
  parameter int TAG_W     = 8,
  parameter int NUM_WB    = 7,
  parameter int PAYLOAD_W = 110
);
  // Dispatch channel
  logic                    disp_valid;
  logic                    disp_ready;
  logic [PAYLOAD_W-1:0]    disp_payload;
  logic [TAG_W-1:0]        disp_src1;
  logic [TAG_W-1:0]        disp_src2;
  logic                    disp_rdy1;
  logic                    disp_rdy2;
  // Writeback broadcast, channel k at wb_tag[k*TAG_W +: TAG_W]
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  // Issue channel
  logic                    issue_valid;
  logic                    issue_ready;
  logic [PAYLOAD_W-1:0]    issue_payload;
  logic [TAG_W-1:0]        issue_src1;
  logic [TAG_W-1:0]        issue_src2;

  modport master (
    output disp_valid, disp_payload, disp_src1, disp_src2, disp_rdy1, disp_rdy2,
    output wb_valid, wb_tag, issue_ready,
    input  disp_ready, issue_valid, issue_payload, issue_src1, issue_src2
  );

  modport slave (
    input  disp_valid, disp_payload, disp_src1, disp_src2, disp_rdy1, disp_rdy2,
    input  wb_valid, wb_tag, issue_ready,
    output disp_ready, issue_valid, issue_payload, issue_src1, issue_src2
  );
endinterface

// File: rtl/rs_alu_param.sv
// ALU reservation station: holds DEPTH ops waiting on two source tags, wakes them
// from NUM_WB writeback broadcasts and issues the oldest ready op through a
// stallable valid/ready output register.
`timescale 1ns/1ps
module rs_alu_param #(
  parameter  int DEPTH     = 16,
  parameter  int TAG_W     = 8,
  parameter  int NUM_WB    = 7,
  parameter  int PAYLOAD_W = 110,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  rs_alu_param_if.slave    bus,
  output logic [CNT_W-1:0] free_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AGE_W = $clog2(DEPTH);

  // Entry state. Control bits are reset; tags and payload are plain storage.
  logic [DEPTH-1:0]     vld_q;
  logic [DEPTH-1:0]     rdy1_q;
  logic [DEPTH-1:0]     rdy2_q;
  logic [AGE_W-1:0]     age_q     [DEPTH];
  logic [TAG_W-1:0]     src1_q    [DEPTH];
  logic [TAG_W-1:0]     src2_q    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic [CNT_W-1:0]     cnt_q;

  // Issue output register
  logic                 issue_valid_q;
  logic [PAYLOAD_W-1:0] issue_payload_q;
  logic [TAG_W-1:0]     issue_src1_q;
  logic [TAG_W-1:0]     issue_src2_q;

  // Combinational control
  logic                 accept;
  logic                 load;
  logic [IDX_W-1:0]     ins_idx;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [AGE_W-1:0]     sel_age;
  logic                 byp1;
  logic                 byp2;
  logic [DEPTH-1:0]     wake1;
  logic [DEPTH-1:0]     wake2;

  // Backpressure depends only on the registered count, so a freeing entry never helps a full station.
  assign bus.disp_ready = (cnt_q < CNT_W'(DEPTH));
  assign free_count     = CNT_W'(DEPTH) - cnt_q;

  assign accept = bus.disp_valid & bus.disp_ready & ~flush;
  assign load   = sel_valid & (~bus.issue_valid | bus.issue_ready);

  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_payload = issue_payload_q;
  assign bus.issue_src1    = issue_src1_q;
  assign bus.issue_src2    = issue_src2_q;

  // Tag match of every writeback channel against the dispatching op and all stored entries.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    byp1  = 1'b0;
    byp2  = 1'b0;
    wake1 = '0;
    wake2 = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (bus.wb_valid[k]) begin
        if (bus.wb_tag[k*TAG_W +: TAG_W] == bus.disp_src1) byp1 = 1'b1;
        if (bus.wb_tag[k*TAG_W +: TAG_W] == bus.disp_src2) byp2 = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.wb_tag[k*TAG_W +: TAG_W] == src1_q[i]) wake1[i] = 1'b1;
          if (bus.wb_tag[k*TAG_W +: TAG_W] == src2_q[i]) wake2[i] = 1'b1;
        end
      end
    end
  end

  // Lowest-index free entry; scanning downwards lets the lowest hit win.
  always_comb begin
    ins_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) ins_idx = IDX_W'(i);
    end
  end

  // Oldest-first select among entries whose registered ready bits are both set.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && rdy1_q[i] && rdy2_q[i] && (!sel_valid || age_q[i] > sel_age)) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

  // Entry control: insert, wakeup, age maintenance and clear-on-select.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      vld_q  <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (flush) begin
      vld_q  <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load && sel_idx == IDX_W'(i)) begin
          vld_q[i] <= 1'b0;
          age_q[i] <= '0;
        end else if (accept && ins_idx == IDX_W'(i)) begin
          vld_q[i]  <= 1'b1;
          age_q[i]  <= '0;
          rdy1_q[i] <= bus.disp_rdy1 | byp1;
          rdy2_q[i] <= bus.disp_rdy2 | byp2;
        end else if (vld_q[i]) begin
          // Insert ages every survivor; removing age A closes the gap above it.
          age_q[i]  <= age_q[i] + AGE_W'(accept) - AGE_W'(load && (age_q[i] > sel_age));
          rdy1_q[i] <= rdy1_q[i] | wake1[i];
          rdy2_q[i] <= rdy2_q[i] | wake2[i];
        end
      end
    end
  end

  // Tag/payload storage, written on accept only.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; vld_q alone decides whether their contents mean anything.
    if (accept) begin
      payload_q[ins_idx] <= bus.disp_payload;
      src1_q[ins_idx]    <= bus.disp_src1;
      src2_q[ins_idx]    <= bus.disp_src2;
    end
  end

  // Occupancy counter: +accept -select, cleared by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(load);
    end
  end

  // Issue register: loads the selected op, holds while stalled, drops after a handshake with nothing behind it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid_q   <= 1'b0;
      issue_payload_q <= '0;
      issue_src1_q    <= '0;
      issue_src2_q    <= '0;
    end else if (flush) begin
      issue_valid_q   <= 1'b0;
      issue_payload_q <= '0;
      issue_src1_q    <= '0;
      issue_src2_q    <= '0;
    end else if (load) begin
      issue_valid_q   <= 1'b1;
      issue_payload_q <= payload_q[sel_idx];
      issue_src1_q    <= src1_q[sel_idx];
      issue_src2_q    <= src2_q[sel_idx];
    end else if (bus.issue_ready) begin
      issue_valid_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_alu_param.sv
// Self-checking bench for rs_alu_param: table of single-op wakeup vectors plus
// directed sequences; issued ops are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_rs_alu_param;

  localparam int DEPTH     = 16;
  localparam int TAG_W     = 8;
  localparam int NUM_WB    = 7;
  localparam int PAYLOAD_W = 110;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic [CNT_W-1:0] free_count;

  rs_alu_param_if #(.TAG_W(TAG_W), .NUM_WB(NUM_WB), .PAYLOAD_W(PAYLOAD_W)) bus ();

  rs_alu_param #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .bus        (bus.slave),
    .free_count (free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PAYLOAD_W-1:0] payload;
    logic [TAG_W-1:0]     src1;
    logic [TAG_W-1:0]     src2;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0] src1;
    logic [TAG_W-1:0] src2;
    logic             rdy1;
    logic             rdy2;
    int               ch_a;
    logic [TAG_W-1:0] tag_a;
    int               ch_b;
    logic [TAG_W-1:0] tag_b;
    int               wake_d;   // cycle (relative to accept edge) of the broadcast; -1 none
    int               exp_lat;  // edges after accept until issue_valid is seen
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every completed handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && bus.issue_valid && bus.issue_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got payload %0h expected no issue", bus.issue_payload);
      end else begin
        mon_e = sb.pop_front();
        check("issue_payload", bus.issue_payload, mon_e.payload);
        check("issue_src1", bus.issue_src1, mon_e.src1);
        check("issue_src2", bus.issue_src2, mon_e.src2);
      end
    end
  end

  function automatic logic [PAYLOAD_W-1:0] make_payload(input int id);
    return {32'(id), 32'h1000 + 32'(id) * 4, 8'(id), 4'(id), 1'b1, 1'b0, 32'hA500_0000 ^ 32'(id)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_valid   = 1'b0;
    bus.disp_payload = '0;
    bus.disp_src1    = '0;
    bus.disp_src2    = '0;
    bus.disp_rdy1    = 1'b0;
    bus.disp_rdy2    = 1'b0;
    bus.wb_valid     = '0;
    bus.wb_tag       = '0;
  endtask

  task automatic drive_disp(input logic [PAYLOAD_W-1:0] p, input logic [TAG_W-1:0] s1,
                            input logic [TAG_W-1:0] s2, input logic r1, input logic r2);
    bus.disp_valid   = 1'b1;
    bus.disp_payload = p;
    bus.disp_src1    = s1;
    bus.disp_src2    = s2;
    bus.disp_rdy1    = r1;
    bus.disp_rdy2    = r2;
  endtask

  task automatic push_exp(input logic [PAYLOAD_W-1:0] p, input logic [TAG_W-1:0] s1,
                          input logic [TAG_W-1:0] s2);
    exp_t e;
    e.payload = p;
    e.src1    = s1;
    e.src2    = s2;
    sb.push_back(e);
  endtask

  task automatic drive_wb(input int ch_a, input logic [TAG_W-1:0] tag_a,
                          input int ch_b, input logic [TAG_W-1:0] tag_b);
    bus.wb_valid = '0;
    bus.wb_tag   = '0;
    bus.wb_valid[ch_a] = 1'b1;
    bus.wb_tag[ch_a*TAG_W +: TAG_W] = tag_a;
    bus.wb_valid[ch_b] = 1'b1;
    bus.wb_tag[ch_b*TAG_W +: TAG_W] = tag_b;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.issue_valid) && n < 40) begin
      step();
      n++;
    end
    check(name, (sb.size() == 0 && !bus.issue_valid), 1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h11, 8'h12, 1'b1, 1'b1, 0, 8'h00, 0, 8'h00, -1, 1};
    vecs[1] = '{8'h30, 8'h40, 1'b1, 1'b0, 0, 8'h40, 0, 8'h40,  0, 1};  // same-cycle bypass
    vecs[2] = '{8'h50, 8'h51, 1'b0, 1'b1, 6, 8'h50, 6, 8'h50,  0, 1};
    vecs[3] = '{8'h60, 8'h61, 1'b0, 1'b1, 2, 8'h60, 2, 8'h60,  1, 2};
    vecs[4] = '{8'h70, 8'h71, 1'b1, 1'b0, 4, 8'h71, 4, 8'h71,  3, 4};
    vecs[5] = '{8'h7a, 8'h7a, 1'b0, 1'b0, 5, 8'h7a, 5, 8'h7a,  2, 3};
    vecs[6] = '{8'h81, 8'h82, 1'b0, 1'b0, 1, 8'h81, 5, 8'h82,  1, 2};  // two channels at once

    // Reset state
    reset_n = 1'b0;
    flush   = 1'b0;
    bus.issue_ready = 1'b0;
    idle_inputs();
    #12;
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_disp_ready", bus.disp_ready, 1);
    check("rst_free_count", free_count, DEPTH);
    check("rst_issue_payload", bus.issue_payload, 0);
    #1 reset_n = 1'b1;
    step();

    // Test 1: single ready op, one-cycle latency
    bus.issue_ready = 1'b1;
    drive_disp(make_payload(1), 8'h01, 8'h02, 1'b1, 1'b1);
    push_exp(make_payload(1), 8'h01, 8'h02);
    step();
    idle_inputs();
    check("t1_free_after_accept", free_count, DEPTH - 1);
    check("t1_not_yet_valid", bus.issue_valid, 0);
    step();
    check("t1_issue_valid", bus.issue_valid, 1);
    check("t1_free_back", free_count, DEPTH);
    step();
    check("t1_issue_idle", bus.issue_valid, 0);

    // Table-driven wakeup/bypass latency vectors
    for (int v = 0; v < 7; v++) begin
      int lat = 0;
      drive_disp(make_payload(100 + v), vecs[v].src1, vecs[v].src2, vecs[v].rdy1, vecs[v].rdy2);
      push_exp(make_payload(100 + v), vecs[v].src1, vecs[v].src2);
      if (vecs[v].wake_d == 0) drive_wb(vecs[v].ch_a, vecs[v].tag_a, vecs[v].ch_b, vecs[v].tag_b);
      step();
      idle_inputs();
      for (int c = 1; c <= 10; c++) begin
        if (c == vecs[v].wake_d) drive_wb(vecs[v].ch_a, vecs[v].tag_a, vecs[v].ch_b, vecs[v].tag_b);
        else idle_inputs();
        step();
        if (bus.issue_valid) begin
          lat = c;
          break;
        end
      end
      idle_inputs();
      check("vec_latency", lat, vecs[v].exp_lat);
      step();
      check("vec_free_count", free_count, DEPTH);
    end
    drain("vec_drain");

    // Test 2: not-ready A overtaken by ready B, then woken on channel 3
    drive_disp(make_payload(300), 8'h21, 8'h22, 1'b0, 1'b1);
    step();
    drive_disp(make_payload(301), 8'h31, 8'h32, 1'b1, 1'b1);
    push_exp(make_payload(301), 8'h31, 8'h32);
    push_exp(make_payload(300), 8'h21, 8'h22);
    step();
    idle_inputs();
    bus.wb_valid[3] = 1'b1;
    bus.wb_tag[3*TAG_W +: TAG_W] = 8'h21;
    step();
    idle_inputs();
    check("t2_b_first", bus.issue_payload, make_payload(301));
    step();
    check("t2_a_second", bus.issue_payload, make_payload(300));
    drain("t2_drain");

    // Test 3: fill under stall, backpressure, then in-order release at full rate
    bus.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_disp(make_payload(200 + i), 8'(i), 8'(i + 1), 1'b1, 1'b1);
      push_exp(make_payload(200 + i), 8'(i), 8'(i + 1));
      step();
    end
    check("t3_full_not_ready", bus.disp_ready, 0);
    check("t3_full_free", free_count, 0);
    drive_disp(make_payload(250), 8'h55, 8'h56, 1'b1, 1'b1);  // refused: station full
    step();
    idle_inputs();
    check("t3_still_full", free_count, 0);
    step();
    step();
    check("t3_hold_valid", bus.issue_valid, 1);
    check("t3_hold_payload", bus.issue_payload, make_payload(200));
    bus.issue_ready = 1'b1;
    repeat (DEPTH + 1) step();
    check("t3_all_issued", sb.size(), 0);
    check("t3_idle_after", bus.issue_valid, 0);
    check("t3_free_after", free_count, DEPTH);

    // Test 5: flush with 5 queued entries and a loaded issue register
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_disp(make_payload(400 + i), 8'h90, 8'h91, 1'b1, 1'b1);
      step();
    end
    idle_inputs();
    check("t5_pre_valid", bus.issue_valid, 1);
    check("t5_pre_free", free_count, DEPTH - 5);
    flush = 1'b1;
    drive_disp(make_payload(450), 8'h92, 8'h93, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    idle_inputs();
    check("t5_flush_valid", bus.issue_valid, 0);
    check("t5_flush_free", free_count, DEPTH);
    check("t5_flush_ready", bus.disp_ready, 1);
    step();
    check("t5_drop_free", free_count, DEPTH);
    check("t5_drop_valid", bus.issue_valid, 0);
    bus.issue_ready = 1'b1;
    drive_disp(make_payload(460), 8'h94, 8'h95, 1'b1, 1'b1);
    push_exp(make_payload(460), 8'h94, 8'h95);
    step();
    idle_inputs();
    drain("t5_post_flush_drain");

    // Test 6: asynchronous reset between clock edges
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_disp(make_payload(500 + i), 8'hA0, 8'hA1, 1'b1, 1'b1);
      step();
    end
    idle_inputs();
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", bus.issue_valid, 0);
    check("t6_async_free", free_count, DEPTH);
    check("t6_async_ready", bus.disp_ready, 1);
    check("t6_async_payload", bus.issue_payload, 0);
    check("t6_async_src1", bus.issue_src1, 0);
    step();
    #2 reset_n = 1'b1;
    step();
    bus.issue_ready = 1'b1;
    drive_disp(make_payload(600), 8'hB0, 8'hB1, 1'b1, 1'b1);
    push_exp(make_payload(600), 8'hB0, 8'hB1);
    step();
    idle_inputs();
    drain("t6_post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
